fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding and load-use hazard controller for the execute stage. Tracks dest regs of
//  instructions in pipeline stages d2 (EX/MEM) and d3 (MEM/WB). Drives the per-operand
//  select lines of data_path_mux1 (operand 1) and data_path_mux2 (operand 2). Stalls stage 1
//  and inserts one bubble when a load in d2 feeds the instruction now in stage 1.
// PARAMETERS
//  REG_AW   5   register address width
//  CNT_W    16  width of saturating perf counters
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       async active-high reset
//  s1_valid       in   1       stage-1 (execute) instruction valid
//  s1_rs1         in   REG_AW  source reg 1 of stage-1 instruction
//  s1_rs2         in   REG_AW  source reg 2 of stage-1 instruction
//  s1_rs1_used    in   1       operand 1 is read from the register file
//  s1_rs2_used    in   1       operand 2 is read from the register file
//  s1_rd          in   REG_AW  destination reg of stage-1 instruction
//  s1_we          in   1       stage-1 instruction writes rd
//  s1_load        in   1       stage-1 instruction is a memory load
//  flush          in   1       kill stage-1 instruction (branch taken)
//  alu_alu_s1     out  1       op1 <- alu_out_d2
//  bypass_alu1    out  1       op1 <- alu_out_d3
//  dmem_alu1      out  1       op1 <- DOut_d3
//  alu_alu_s2     out  1       op2 <- alu_out_d2
//  bypass_alu2    out  1       op2 <- alu_out_d3
//  dmem_alu2      out  1       op2 <- DOut_d3
//  stall          out  1       hold stage 1 and earlier this cycle
//  fwd_cnt        out  CNT_W   count of cycles with any forward select high
//  stall_cnt      out  CNT_W   count of stall cycles
// BEHAVIOUR
//  - State: d2_{v,rd,we,ld} and d3_{v,rd,we,ld} regs. Reset (async): all v=0, counters=0.
//    All outputs are therefore 0 out of reset.
//  - Match: dN_hit(rs) = dN_v & dN_we & (dN_rd==rs) & (rs!=0) & rs_used & s1_valid.
//  - Per-operand priority, newest producer first. At most one select is high per operand:
//    d2_hit & !d2_ld -> alu_alu_sX
//    d2_hit & d2_ld  -> load-use: raise stall, all selects for this operand 0
//    d3_hit & d3_ld  -> dmem_aluX
//    d3_hit & !d3_ld -> bypass_aluX
//    else            -> all 0 (register-file value)
//  - stall = load-use on op1 OR op2, masked by flush (flush has priority, stall=0).
//  - While stall=1, all six selects are forced to 0.
//  - Selects and stall are combinational from current state and s1_* inputs.
//    Zero added latency.
//  - Per clock edge:
//    d3 <= d2 always.
//    If stall or flush, d2 <= bubble (v=0). Else d2 <= {s1_valid, s1_rd, s1_we, s1_load}.
//  - Load-use resolves in exactly one stall cycle. Next cycle the load is in d3, so dmem_aluX=1.
//  - Register file is write-through. No forwarding beyond d3.
//  - Same rd in d2 and d3: d2 wins (alu_alu_sX, or stall if d2 is a load).
//  - rs1==rs2: both operands get identical selects.
//  - Counters saturate at all-ones and do not wrap.
//    fwd_cnt increments when any of the six selects is 1.
//    stall_cnt increments when stall=1.
//  - Reset mid-stall: bubbles everywhere, stall drops immediately, no spurious selects.
// TESTING
//  - add r3 (d2) then sub r4,r3,r5 in s1 -> alu_alu_s1=1, others 0, stall=0.
//  - add r3, nop, then or r6,r1,r3 -> bypass_alu2=1 in the or's execute cycle.
//  - lw r7 then add r8,r7,r7 -> cycle0 stall=1, selects 0, stall_cnt=1.
//    cycle1 dmem_alu1=dmem_alu2=1, stall=0.
//  - add r2 in d3, sub r2 in d2, s1 reads r2 -> alu_alu_s1=1 only (newest wins).
//  - Writer rd=r0 matched by s1 rs1=r0 -> all selects 0.
//    lw hazard with flush=1 -> stall=0 and d2 bubble.
//  - Assert rst during stall -> all outputs 0 asynchronously.
//    Force 2^CNT_W+3 stalls -> stall_cnt holds at all-ones.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Execute-stage forwarding and load-use hazard control. Keeps a small
//   shadow of the destination register of the instructions now in EX/MEM
//   (d2) and MEM/WB (d3). Picks a forwarding source for each of the two
//   operands of the instruction in stage 1, and stalls for one cycle when
//   a load in d2 feeds that instruction. Two saturating counters record how
//   many cycles forwarded data and how many cycles stalled.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_valid,
  input  logic [REG_AW-1:0] s1_rs1,
  input  logic [REG_AW-1:0] s1_rs2,
  input  logic              s1_rs1_used,
  input  logic              s1_rs2_used,
  input  logic [REG_AW-1:0] s1_rd,
  input  logic              s1_we,
  input  logic              s1_load,
  input  logic              flush,
  output logic              alu_alu_s1,
  output logic              bypass_alu1,
  output logic              dmem_alu1,
  output logic              alu_alu_s2,
  output logic              bypass_alu2,
  output logic              dmem_alu2,
  output logic              stall,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // What the hazard logic needs to know about an instruction further down
  // the pipe: whether it is real, which register it writes, whether it
  // writes at all, and whether the result comes from memory.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } stage_t;

  stage_t r_d2;
  stage_t r_d3;

  logic [CNT_W-1:0] r_fwd_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Producer/consumer matches. Register 0 is hard-wired zero and is never
  // forwarded; an unused operand or an invalid stage-1 slot never matches.
  logic w_d2_hit1;
  logic w_d2_hit2;
  logic w_d3_hit1;
  logic w_d3_hit2;

  assign w_d2_hit1 = r_d2.v & r_d2.we & (r_d2.rd == s1_rs1) & (s1_rs1 != '0)
                     & s1_rs1_used & s1_valid;
  assign w_d2_hit2 = r_d2.v & r_d2.we & (r_d2.rd == s1_rs2) & (s1_rs2 != '0)
                     & s1_rs2_used & s1_valid;
  assign w_d3_hit1 = r_d3.v & r_d3.we & (r_d3.rd == s1_rs1) & (s1_rs1 != '0)
                     & s1_rs1_used & s1_valid;
  assign w_d3_hit2 = r_d3.v & r_d3.we & (r_d3.rd == s1_rs2) & (s1_rs2 != '0)
                     & s1_rs2_used & s1_valid;

  logic w_lu1;
  logic w_lu2;
  logic w_stall;
  logic w_alu_alu_s1;
  logic w_bypass_alu1;
  logic w_dmem_alu1;
  logic w_alu_alu_s2;
  logic w_bypass_alu2;
  logic w_dmem_alu2;
  logic w_any_fwd;

  // Per-operand source selection, newest producer first; a stall blanks
  // every select so the held instruction never consumes partial data.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    w_lu1         = 1'b0;
    w_lu2         = 1'b0;
    w_stall       = 1'b0;
    w_alu_alu_s1  = 1'b0;
    w_bypass_alu1 = 1'b0;
    w_dmem_alu1   = 1'b0;
    w_alu_alu_s2  = 1'b0;
    w_bypass_alu2 = 1'b0;
    w_dmem_alu2   = 1'b0;

    // Operand 1
    if (w_d2_hit1) begin
      if (r_d2.ld) w_lu1        = 1'b1;
      else         w_alu_alu_s1 = 1'b1;
    end else if (w_d3_hit1) begin
      if (r_d3.ld) w_dmem_alu1   = 1'b1;
      else         w_bypass_alu1 = 1'b1;
    end

    // Operand 2
    if (w_d2_hit2) begin
      if (r_d2.ld) w_lu2        = 1'b1;
      else         w_alu_alu_s2 = 1'b1;
    end else if (w_d3_hit2) begin
      if (r_d3.ld) w_dmem_alu2   = 1'b1;
      else         w_bypass_alu2 = 1'b1;
    end

    // A flushed instruction is discarded anyway, so it never needs to wait.
    w_stall = (w_lu1 | w_lu2) & ~flush;

    if (w_stall) begin
      w_alu_alu_s1  = 1'b0;
      w_bypass_alu1 = 1'b0;
      w_dmem_alu1   = 1'b0;
      w_alu_alu_s2  = 1'b0;
      w_bypass_alu2 = 1'b0;
      w_dmem_alu2   = 1'b0;
    end
  end

  assign w_any_fwd = w_alu_alu_s1 | w_bypass_alu1 | w_dmem_alu1 |
                     w_alu_alu_s2 | w_bypass_alu2 | w_dmem_alu2;

  // Advance the producer shadow: d3 always takes d2; d2 takes a bubble on a
  // stall (the consumer is held) or a flush (the instruction is killed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d2 <= '0;
      r_d3 <= '0;
    end else begin
      // NOTE: non-blocking assignments make d3 capture the old d2, not the
      // value d2 is being given on this same edge.
      r_d3 <= r_d2;
      if (w_stall || flush) begin
        r_d2 <= '0;
      end else begin
        r_d2.v  <= s1_valid;
        r_d2.rd <= s1_rd;
        r_d2.we <= s1_we;
        r_d2.ld <= s1_load;
      end
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_any_fwd && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign alu_alu_s1  = w_alu_alu_s1;
  assign bypass_alu1 = w_bypass_alu1;
  assign dmem_alu1   = w_dmem_alu1;
  assign alu_alu_s2  = w_alu_alu_s2;
  assign bypass_alu2 = w_bypass_alu2;
  assign dmem_alu2   = w_dmem_alu2;
  assign stall       = w_stall;
  assign fwd_cnt     = r_fwd_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl
//   Directed bench: a cycle-by-cycle instruction table with hand-computed
//   selects, then hand-written sequences for load-use counting, reset during
//   a stall, and counter saturation.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;

  // Expected-output bit order: {alu1, byp1, dmem1, alu2, byp2, dmem2, stall}
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_A1   = 7'b1000000;
  localparam logic [6:0] E_D1   = 7'b0010000;
  localparam logic [6:0] E_A2   = 7'b0001000;
  localparam logic [6:0] E_B2   = 7'b0000100;
  localparam logic [6:0] E_D2   = 7'b0000010;
  localparam logic [6:0] E_ST   = 7'b0000001;

  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
    logic              fl;
    logic [6:0]        exp;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              s1_valid;
  logic [REG_AW-1:0] s1_rs1;
  logic [REG_AW-1:0] s1_rs2;
  logic              s1_rs1_used;
  logic              s1_rs2_used;
  logic [REG_AW-1:0] s1_rd;
  logic              s1_we;
  logic              s1_load;
  logic              flush;
  logic              alu_alu_s1;
  logic              bypass_alu1;
  logic              dmem_alu1;
  logic              alu_alu_s2;
  logic              bypass_alu2;
  logic              dmem_alu2;
  logic              stall;
  logic [CNT_W-1:0]  fwd_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks;
  int n_pass;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s1_valid    (s1_valid),
    .s1_rs1      (s1_rs1),
    .s1_rs2      (s1_rs2),
    .s1_rs1_used (s1_rs1_used),
    .s1_rs2_used (s1_rs2_used),
    .s1_rd       (s1_rd),
    .s1_we       (s1_we),
    .s1_load     (s1_load),
    .flush       (flush),
    .alu_alu_s1  (alu_alu_s1),
    .bypass_alu1 (bypass_alu1),
    .dmem_alu1   (dmem_alu1),
    .alu_alu_s2  (alu_alu_s2),
    .bypass_alu2 (bypass_alu2),
    .dmem_alu2   (dmem_alu2),
    .stall       (stall),
    .fwd_cnt     (fwd_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic [REG_AW-1:0] a,
                              input logic [REG_AW-1:0] b, input logic ua,
                              input logic ub, input logic [REG_AW-1:0] rd,
                              input logic we, input logic ld, input logic fl,
                              input logic [6:0] e);
    vec_t t;
    t.valid = v;  t.rs1 = a;  t.rs2 = b;  t.u1 = ua;  t.u2 = ub;
    t.rd = rd;    t.we = we;  t.ld = ld;  t.fl = fl;  t.exp = e;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    s1_valid    = t.valid;
    s1_rs1      = t.rs1;
    s1_rs2      = t.rs2;
    s1_rs1_used = t.u1;
    s1_rs2_used = t.u2;
    s1_rd       = t.rd;
    s1_we       = t.we;
    s1_load     = t.ld;
    flush       = t.fl;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [6:0] outs();
    return {alu_alu_s1, bypass_alu1, dmem_alu1,
            alu_alu_s2, bypass_alu2, dmem_alu2, stall};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[24];
  vec_t v_idle;
  vec_t v_lw;
  vec_t v_use;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    v_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
    v_lw   = mk(1, 1, 0, 1, 0, 7, 1, 1, 0, E_NONE);  // lw  r7,0(r1)
    v_use  = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, E_ST);    // add r8,r7,r7

    //          v  rs1 rs2 u1 u2 rd we ld fl expected
    tbl[0]  = mk(1,  1,  2, 1, 1,  3, 1, 0, 0, E_NONE); // add r3,r1,r2
    tbl[1]  = mk(1,  3,  5, 1, 1,  4, 1, 0, 0, E_A1);   // sub r4,r3,r5
    tbl[2]  = mk(1,  1,  2, 1, 1,  3, 1, 0, 0, E_NONE); // add r3,r1,r2
    tbl[3]  = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, E_NONE); // nop
    tbl[4]  = mk(1,  1,  3, 1, 1,  6, 1, 0, 0, E_B2);   // or  r6,r1,r3
    tbl[5]  = mk(1,  1,  0, 1, 0,  7, 1, 1, 0, E_NONE); // lw  r7
    tbl[6]  = mk(1,  7,  7, 1, 1,  8, 1, 0, 0, E_ST);   // add r8,r7,r7 stall
    tbl[7]  = mk(1,  7,  7, 1, 1,  8, 1, 0, 0, E_D1 | E_D2); // replay
    tbl[8]  = mk(1,  1,  1, 1, 1,  2, 1, 0, 0, E_NONE); // add r2
    tbl[9]  = mk(1,  1,  1, 1, 1,  2, 1, 0, 0, E_NONE); // sub r2
    tbl[10] = mk(1,  2,  0, 1, 1,  9, 1, 0, 0, E_A1);   // reads r2: d2 wins
    tbl[11] = mk(1,  1,  1, 1, 1,  0, 1, 0, 0, E_NONE); // writes r0
    tbl[12] = mk(1,  0,  0, 1, 1, 10, 1, 0, 0, E_NONE); // reads r0
    tbl[13] = mk(1,  5,  0, 1, 0, 11, 1, 1, 0, E_NONE); // lw r11
    tbl[14] = mk(1, 11,  0, 1, 0, 12, 1, 0, 1, E_NONE); // load-use, flushed
    tbl[15] = mk(1, 11, 12, 1, 1, 13, 1, 0, 0, E_D1);   // d2 was bubbled
    tbl[16] = mk(1, 13, 13, 1, 1, 14, 0, 0, 0, E_A1 | E_A2); // rs1==rs2
    tbl[17] = mk(1, 14, 13, 1, 1,  0, 0, 0, 0, E_B2);   // d2 we=0 ignored
    tbl[18] = mk(1,  1,  2, 1, 1, 15, 1, 0, 0, E_NONE); // add r15
    tbl[19] = mk(1,  3,  0, 1, 0, 16, 1, 1, 0, E_NONE); // lw r16
    tbl[20] = mk(1, 15, 16, 1, 1, 17, 1, 0, 0, E_ST);   // op2 load-use
    tbl[21] = mk(1, 15, 16, 1, 1, 17, 1, 0, 0, E_D2);   // replay
    tbl[22] = mk(1, 17,  0, 0, 1, 18, 1, 0, 0, E_NONE); // rs1 not used
    tbl[23] = mk(0, 17,  0, 1, 1,  0, 0, 0, 0, E_NONE); // s1 invalid

    // Reset state, with an input that would match r0 if anything leaked.
    drive(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, E_NONE));
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("reset_sel", 32'(outs()), 32'(E_NONE));
    check("reset_cnt", {fwd_cnt, stall_cnt}, 32'd0);
    drive(v_idle);
    @(negedge clk);
    rst = 1'b0;

    // Table: one instruction per cycle, state carries over between rows.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    @(negedge clk);
    drive(v_idle);
    #2;
    check("tbl_fwd_cnt", 32'(fwd_cnt), 32'd8);
    check("tbl_stall_cnt", 32'(stall_cnt), 32'd2);

    // Load-use: one stall cycle, then memory data forwarded to both operands.
    do_reset();
    drive(v_lw);
    @(negedge clk);
    drive(v_use);
    #2;
    check("lu_stall", 32'(outs()), 32'(E_ST));
    @(negedge clk);
    #2;
    check("lu_replay", 32'(outs()), 32'(E_D1 | E_D2));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_fwd_cnt0", 32'(fwd_cnt), 32'd0);
    @(negedge clk);
    drive(v_idle);
    #2;
    check("lu_fwd_cnt1", 32'(fwd_cnt), 32'd1);

    // Reset asserted in the middle of a stall cycle.
    drive(v_lw);
    @(negedge clk);
    drive(v_use);
    #2;
    check("rs_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_async_sel", 32'(outs()), 32'(E_NONE));
    check("rs_async_cnt", {fwd_cnt, stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rs_after_sel", 32'(outs()), 32'(E_NONE));

    // Saturation: 2^CNT_W + 3 load-use stalls.
    do_reset();
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      @(negedge clk);
      drive(v_lw);
      if (k == 10) begin
        #2;
        check("sat_mid_cnt", 32'(stall_cnt), 32'd10);
      end
      @(negedge clk);
      drive(v_use);
    end
    #2;
    check("sat_last_stall", 32'(stall), 32'd1);
    @(negedge clk);
    drive(v_idle);
    #2;
    check("sat_stall_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
